// File: rtl/aes_wide_pkg.sv
// Shared types and AES-128 round helpers for the wide stream cipher.
// The S-box is computed (GF(2^8) inverse + affine) rather than tabled.
package aes_wide_pkg;

    localparam int AES_BLK_W    = 128;
    localparam int AES_PIPE_LAT = 11;
    localparam int MAX_LANES    = 8;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef struct packed {
        logic [MAX_LANES-1:0]     keep;
        aes_blk_t [MAX_LANES-1:0] data;
    } beat_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the field inverse (and maps 0 to 0)
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic aes_blk_t sub_shift(input aes_blk_t s);
        aes_blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic aes_blk_t mix_cols(input aes_blk_t s);
        aes_blk_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic aes_blk_t next_key(input aes_blk_t k, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
             ^ {rcon, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic aes_blk_t aes_round(input aes_blk_t s, input aes_blk_t rk,
                                           input logic last);
        aes_blk_t t;
        t = sub_shift(s);
        if (!last) t = mix_cols(t);
        return t ^ rk;
    endfunction

endpackage

// File: rtl/aes_cipher_pipe.sv
// One AES-128 encrypt lane: whitening stage plus 10 registered rounds.
// Round keys are expanded combinationally; the key must hold while busy.
module aes_cipher_pipe
    import aes_wide_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  aes_blk_t key,
    input  aes_blk_t data_in,
    input  logic     data_in_valid,
    output aes_blk_t data_out,
    output logic     data_out_valid
);

    localparam int NR = AES_PIPE_LAT - 1;

    aes_blk_t         rk [AES_PIPE_LAT];
    aes_blk_t         st [AES_PIPE_LAT];
    logic [NR:0]      vld;
    logic [7:0]       rc;

    always_comb begin
        rc    = 8'h01;
        rk[0] = key;
        for (int r = 1; r <= NR; r++) begin
            rk[r] = next_key(rk[r-1], rc);
            rc    = xtime(rc);
        end
    end

    always_ff @(posedge clk) begin
        st[0] <= data_in ^ rk[0];
        for (int r = 1; r <= NR; r++)
            st[r] <= aes_round(st[r-1], rk[r], r == NR);
    end

    always_ff @(posedge clk) begin
        if (!rst) vld <= '0;
        else      vld <= {vld[NR-1:0], data_in_valid};
    end

    assign data_out       = st[NR];
    assign data_out_valid = vld[NR];

endmodule

// File: rtl/aes_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with registered read data.
// Pointers wrap at DEPTH, so DEPTH need not be a power of two.
module aes_stream_fifo
    import aes_wide_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0]    remain;
    logic             do_pop;

    assign valid  = count != '0;
    assign do_pop = pop & valid;
    assign remain = count - CW'(do_pop);
    assign wr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_nxt = !do_pop ? rd_ptr
                  : (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // rdata always holds the head entry; a push into an emptying FIFO bypasses mem
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (push) wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            count  <= remain + CW'(push);
            if (push && remain == '0) rdata <= wdata;
            else if (remain != '0)    rdata <= mem[rd_nxt];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(pop && count == '0));

endmodule

// File: rtl/aes_cipher_wide_stream.sv
// N-lane AES-128 encrypt stream with credit flow control and output FIFO.
// A beat is accepted only with a reserved FIFO slot, so lanes never stall.
module aes_cipher_wide_stream
    import aes_wide_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int PIPE_LAT   = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            key_load,
    input  logic [AES_BLK_W-1:0]            key_in,
    output logic                            key_ready,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [AES_BLK_W*N_LANES-1:0]    in_data,
    input  logic [N_LANES-1:0]              in_keep,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [AES_BLK_W*N_LANES-1:0]    out_data,
    output logic [N_LANES-1:0]              out_keep,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] inflight
);

    localparam int W  = AES_BLK_W * N_LANES;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < PIPE_LAT + 2) begin : g_depth_chk
        $error("FIFO_DEPTH must be >= PIPE_LAT+2");
    end
    if (PIPE_LAT != AES_PIPE_LAT) begin : g_lat_chk
        $error("PIPE_LAT must equal the aes_cipher_pipe latency");
    end
    if (N_LANES < 1 || N_LANES > MAX_LANES) begin : g_lane_chk
        $error("N_LANES out of range 1..8");
    end

    aes_blk_t           key_reg;
    logic [CW-1:0]      pipe_cnt;
    logic [CW-1:0]      fifo_cnt;
    logic [N_LANES:0]   sr [PIPE_LAT];
    logic [N_LANES:0]   tail;
    logic [W-1:0]       lane_out;
    logic [N_LANES-1:0] lane_vld;
    logic [N_LANES+W-1:0] fifo_rdata;
    logic               fire_in, key_fire, push, pop;

    assign inflight  = pipe_cnt + fifo_cnt;
    assign key_ready = rst & (pipe_cnt == '0);
    assign in_ready  = rst & ~key_load & (inflight < CW'(FIFO_DEPTH));
    assign fire_in   = in_valid & in_ready;
    assign key_fire  = key_load & key_ready;
    assign tail      = sr[PIPE_LAT-1];
    assign push      = tail[N_LANES];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst)          key_reg <= '0;
        else if (key_fire) key_reg <= key_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {fire_in, in_keep};
            for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pipe_cnt <= '0;
        else begin
            case ({fire_in, push})
                2'b10:   pipe_cnt <= pipe_cnt + 1'b1;
                2'b01:   pipe_cnt <= pipe_cnt - 1'b1;
                default: pipe_cnt <= pipe_cnt;
            endcase
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        aes_cipher_pipe u_pipe (
            .clk            (clk),
            .rst            (rst),
            .key            (key_reg),
            .data_in        (in_data[AES_BLK_W*g +: AES_BLK_W]),
            .data_in_valid  (fire_in),
            .data_out       (lane_out[AES_BLK_W*g +: AES_BLK_W]),
            .data_out_valid (lane_vld[g])
        );
    end

    aes_stream_fifo #(
        .WIDTH (N_LANES + W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({tail[N_LANES-1:0], lane_out}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (out_valid),
        .count (fifo_cnt)
    );

    assign out_keep = fifo_rdata[W +: N_LANES];
    assign out_data = fifo_rdata[W-1:0];

    a_lane_align: assert property (@(posedge clk) disable iff (!rst)
        lane_vld == {N_LANES{push}});
    a_key_stable: assert property (@(posedge clk) disable iff (!rst)
        pipe_cnt != '0 |-> !key_fire);
    a_credit: assert property (@(posedge clk) disable iff (!rst)
        inflight <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_aes_cipher_wide_stream.sv
// Scoreboard bench for aes_cipher_wide_stream using published AES-128 vectors.
// Driver pushes expected beats on acceptance; a negedge monitor pops and compares.
module tb_aes_cipher_wide_stream;

    localparam int N  = 4;
    localparam int PL = 11;
    localparam int FD = 16;
    localparam int W  = 128 * N;
    localparam int CW = $clog2(FD + 1);

    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB [5] = '{
        128'h3243f6a8885a308d313198a2e0370734,
        128'h6bc1bee22e409f96e93d7e117393172a,
        128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef,
        128'hf69f2445df4f9b17ad2b417be66c3710};
    localparam logic [127:0] CB [5] = '{
        128'h3925841d02dc09fbdc118597196a0b32,
        128'h3ad77bb40d7a3660a89ecaf32466ef97,
        128'hf5d3d58503b9699de785895a96fdbaaf,
        128'h43b1cd7f598ece23881b00e3ed030688,
        128'h7b0c785e27e8ad3f8223207104725dd4};

    logic          clk = 1'b0;
    logic          rst;
    logic          key_load;
    logic [127:0]  key_in;
    logic          key_ready;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [N-1:0]  in_keep;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [N-1:0]  out_keep;
    logic [CW-1:0] inflight;

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] keep;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t exp_q[$];
    int   out_cyc_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   stalls = 0;

    aes_cipher_wide_stream #(
        .N_LANES    (N),
        .PIPE_LAT   (PL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_ready (key_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=%0h want=none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data, mon_e.data);
                chk("out_keep", W'(out_keep), W'(mon_e.keep));
                if (mon_e.lat) chk("latency", W'(cyc - mon_e.cyc), W'(PL + 1));
            end
            out_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void mk(input int b, output logic [W-1:0] d, output logic [W-1:0] e);
        int idx;
        for (int l = 0; l < N; l++) begin
            idx = (b * 3 + l) % 5;
            d[128*l +: 128] = PB[idx];
            e[128*l +: 128] = CB[idx];
        end
    endfunction

    function automatic logic [W-1:0] rep(input logic [127:0] v);
        return {N{v}};
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [N-1:0] k,
                        input logic [W-1:0] e, input bit lat);
        int n;
        n = 0;
        in_data  = d;
        in_keep  = k;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{data: e, keep: k, cyc: cyc, lat: lat});
                break;
            end
            stalls++;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=stalled want=accept");
                in_valid = 1'b0;
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_key(input logic [127:0] k);
        int n;
        n = 0;
        key_in   = k;
        key_load = 1'b1;
        while (1) begin
            @(negedge clk);
            if (key_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL key_timeout got=0 want=key_ready");
                break;
            end
        end
        tick();
        key_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d, e;
        int n0, s0, acc, w;

        rst       = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_in_ready", W'(in_ready), '0);
        chk("rst_key_ready", W'(key_ready), '0);
        chk("rst_inflight", W'(inflight), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_keep", W'(out_keep), '0);
        tick();
        rst = 1'b1;

        // reset key is all zeros
        @(negedge clk);
        chk("idle_key_ready", W'(key_ready), W'(1));
        chk("idle_in_ready", W'(in_ready), W'(1));
        tick();
        send('0, 4'b1111, rep(CZ), 1'b1);
        drain();

        load_key(KA);
        send(rep(PA), 4'b1011, rep(CA), 1'b1);
        drain();

        // back-to-back stream, mixed lanes, keep patterns incl. zero
        load_key(KB);
        n0 = out_cyc_q.size();
        s0 = stalls;
        for (int b = 0; b < 20; b++) begin
            mk(b, d, e);
            send(d, N'(b * 7), e, b == 0);
        end
        drain();
        chk("stream_stalls", W'(stalls - s0), '0);
        chk("stream_count", W'(out_cyc_q.size() - n0), W'(20));
        if (out_cyc_q.size() >= n0 + 20)
            chk("stream_rate", W'(out_cyc_q[n0+19] - out_cyc_q[n0]), W'(19));

        // full backpressure: exactly FD credits
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 60; c++) begin
            mk(acc, d, e);
            in_data  = d;
            in_keep  = N'(acc);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{data: e, keep: N'(acc), cyc: cyc, lat: 1'b0});
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_accepted", W'(acc), W'(FD));
        chk("full_in_ready", W'(in_ready), '0);
        chk("full_inflight", W'(inflight), W'(FD));
        chk("full_out_valid", W'(out_valid), W'(1));
        tick();
        out_ready = 1'b1;
        drain();

        // key load requested with 3 beats in the lanes
        for (int b = 5; b < 8; b++) begin
            mk(b, d, e);
            send(d, N'(b), e, 1'b0);
        end
        key_in   = KA;
        key_load = 1'b1;
        @(negedge clk);
        chk("busy_key_ready", W'(key_ready), '0);
        chk("keyload_in_ready", W'(in_ready), '0);
        w = 1;
        while (!key_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("key_wait", W'(w), W'(PL + 1));
        tick();
        key_load = 1'b0;
        send(rep(PA), 4'b0110, rep(CA), 1'b0);
        drain();

        // key_load and in_valid together on an empty pipe
        mk(9, d, e);
        key_in   = KB;
        key_load = 1'b1;
        in_data  = d;
        in_keep  = 4'b1001;
        in_valid = 1'b1;
        @(negedge clk);
        chk("same_key_ready", W'(key_ready), W'(1));
        chk("same_in_ready", W'(in_ready), '0);
        tick();
        key_load = 1'b0;
        @(negedge clk);
        chk("next_in_ready", W'(in_ready), W'(1));
        exp_q.push_back('{data: e, keep: 4'b1001, cyc: cyc, lat: 1'b1});
        tick();
        in_valid = 1'b0;
        drain();

        // reset with 4 beats in the FIFO and 5 in the lanes
        out_ready = 1'b0;
        for (int b = 10; b < 14; b++) begin
            mk(b, d, e);
            send(d, N'(b), e, 1'b0);
        end
        repeat (14) tick();
        for (int b = 14; b < 19; b++) begin
            mk(b, d, e);
            send(d, N'(b), e, 1'b0);
        end
        @(negedge clk);
        chk("pre_rst_inflight", W'(inflight), W'(9));
        rst = 1'b0;
        #1;
        chk("in_rst_in_ready", W'(in_ready), '0);
        chk("in_rst_key_ready", W'(key_ready), '0);
        tick();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("post_rst_out_valid", W'(out_valid), '0);
        chk("post_rst_inflight", W'(inflight), '0);
        out_ready = 1'b1;
        repeat (2 * PL) tick();
        send('0, 4'b0101, rep(CZ), 1'b1);
        drain();

        chk("final_queue", W'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
